sram_burst_ctrl: RTL
====================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 8: SRAM word width.
REQ-003 Parameter LEN_WIDTH, default 8: burst length field width.
REQ-004 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake.
REQ-007 i_cmd_write  in  1  1 = burst write, 0 = burst read.
REQ-008 i_cmd_addr  in  ADDR_WIDTH  start word address.
REQ-009 i_cmd_len  in  LEN_WIDTH  word count minus 1 (0 = 1 word).
REQ-010 i_wdata_valid / o_wdata_ready / i_wdata  in/out/in  1/1/DATA_WIDTH  write-data stream.
REQ-011 o_rdata_valid / i_rdata_ready / o_rdata  out/in/out  1/1/DATA_WIDTH  read-data stream.
REQ-012 o_mem_addr / o_mem_write / o_mem_data  out  ADDR_WIDTH/1/DATA_WIDTH  SRAM port drive.
REQ-013 i_mem_data  in  DATA_WIDTH  SRAM read data, valid one cycle after a read-addressed edge.
REQ-014 o_done  out  1  one-cycle pulse at burst completion.
REQ-015 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 States SHALL be IDLE, WRITE, READ and DRAIN.
REQ-017 The command SHALL transfer when i_cmd_valid && o_cmd_ready; o_cmd_ready SHALL be high only in IDLE.
REQ-018 On accept, the block SHALL latch addr and len, clear the word counter, and enter WRITE or READ per i_cmd_write.
REQ-019 In WRITE: o_wdata_ready=1, and each i_wdata_valid beat SHALL drive o_mem_write=1, o_mem_addr=current address, o_mem_data=i_wdata combinationally in the same cycle.
REQ-020 Without a write beat, o_mem_write SHALL be 0 (SRAM performs a harmless read).
REQ-021 Address SHALL increment by 1 per issued word, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00 at default width).
REQ-022 WRITE SHALL end on the beat with counter==len; the next state is IDLE with o_done pulsed.
REQ-023 In READ, a read SHALL be issued (o_mem_write=0, o_mem_addr=current address) only when (fifo_count + inflight - pop) < 2, where pop = o_rdata_valid && i_rdata_ready.
REQ-024 Each issued read SHALL set inflight for exactly one cycle; i_mem_data SHALL be pushed into the 2-entry output FIFO on the following cycle.
REQ-025 After the last read issue (counter==len), the state SHALL go to DRAIN.
REQ-026 DRAIN SHALL exit to IDLE, pulsing o_done, when inflight==0 and the FIFO is empty after the current pop.
REQ-027 o_rdata_valid SHALL equal FIFO not-empty; o_rdata SHALL be the FIFO head; a simultaneous push and pop SHALL keep the count unchanged.
REQ-028 With i_rdata_ready held at 1, a read burst SHALL sustain one word per cycle; first o_rdata_valid SHALL occur 2 cycles after command accept.
REQ-029 With i_rdata_ready=0, the FIFO SHALL never overflow and no SRAM read data SHALL be lost.
REQ-030 o_wdata_ready SHALL be 0 outside WRITE; o_rdata_valid SHALL be 0 in IDLE.

Reset
REQ-031 i_rst SHALL asynchronously force: state IDLE, counters/addr 0, FIFO empty, inflight 0, o_done 0, o_busy 0, o_mem_write 0, o_mem_addr 0, o_mem_data 0.
REQ-032 Reset mid-burst SHALL abandon the burst without o_done; any in-flight read data SHALL be discarded.

Structure
REQ-033 State encodings and the FIFO depth constant (2) SHALL live in a shared package.
REQ-034 The output buffer SHALL be a sub-module named sram_rd_fifo (2-entry, DATA_WIDTH).
REQ-035 The block SHALL connect directly to the team's single-port synchronous sram with matching ADDR_WIDTH/DATA_WIDTH.

Verification
REQ-036 Write addr=0x10, len=3, data 0xA0..0xA3 streamed back-to-back -> SRAM[0x10..0x13]=A0..A3, o_done pulse 4 cycles after accept.
REQ-037 Read the same burst, i_rdata_ready=1 -> o_rdata A0,A1,A2,A3 on consecutive cycles, first valid 2 cycles after accept.
REQ-038 Read len=7 with i_rdata_ready toggling 1,0,0,1,... -> all 8 words delivered in order, none dropped or duplicated.
REQ-039 Write addr=0xFE, len=2 -> writes to 0xFE, 0xFF, 0x00.
REQ-040 Assert i_rst during the third word of a read burst -> all outputs reset immediately, no o_done, next command executes correctly.
REQ-041 len=0 write and len=0 read -> exactly one word transferred, o_done pulsed once each.

Source files
------------

// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM state encodings,
// read-buffer geometry and the read-issue throttle helper.
package sram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Read-data buffer depth and the width needed to count 0..depth.
  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_FIFO_PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  // A new read may be issued only if the word it returns is guaranteed a
  // buffer slot: occupancy after this cycle's pop, plus the read already in
  // flight, must leave room for one more.
  function automatic logic rd_slot_free(
    input logic [RD_FIFO_CNT_W-1:0] count,
    input logic                     inflight,
    input logic                     pop
  );
    logic [RD_FIFO_CNT_W:0] occ;
    occ = {1'b0, count}
        + {{RD_FIFO_CNT_W{1'b0}}, inflight}
        - {{RD_FIFO_CNT_W{1'b0}}, pop};
    return occ < (RD_FIFO_CNT_W + 1)'(RD_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry read-data buffer between the SRAM read port and the read stream.
// Push while full is ignored unless a pop happens in the same cycle; the
// controller's issue throttle guarantees that never occurs in practice.
module sram_rd_fifo
  import sram_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [RD_FIFO_CNT_W-1:0] o_count
);

  logic [DATA_WIDTH-1:0]    mem_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_PTR_W-1:0] wr_ptr_q;
  logic [RD_FIFO_PTR_W-1:0] rd_ptr_q;
  logic [RD_FIFO_CNT_W-1:0] count_q;
  logic                     full;
  logic                     empty;
  logic                     push_ok;
  logic                     pop_ok;

  assign full    = (count_q == RD_FIFO_CNT_W'(RD_FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = i_pop && !empty;
  assign push_ok = i_push && (!full || pop_ok);

  assign o_valid = !empty;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  // Storage array: data only, never reset; validity is tracked by count_q.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + RD_FIFO_PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + RD_FIFO_PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + RD_FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - RD_FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous SRAM. Accepts one burst
// command at a time, streams write data straight onto the SRAM port, and
// returns read data through a 2-entry buffer so the read stream can apply
// backpressure without losing the one-cycle-latency SRAM output.
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // command
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  // write-data stream
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  // read-data stream
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  // SRAM port
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  // status
  output logic                  o_done,
  output logic                  o_busy
);

  state_e                   state_q;
  state_e                   state_d;

  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     cnt_q;
  logic                     rd_vld_p1;   // SRAM read issued last cycle
  logic                     done_q;

  logic                     cmd_accept;
  logic                     wr_beat;
  logic                     rd_issue;
  logic                     last_word;
  logic                     drain_empty;
  logic                     burst_end;

  logic                     fifo_valid;
  logic [DATA_WIDTH-1:0]    fifo_data;
  logic [RD_FIFO_CNT_W-1:0] fifo_count;
  logic                     rd_pop;

  assign cmd_accept  = i_cmd_valid && o_cmd_ready;
  assign last_word   = (cnt_q == len_q);
  assign rd_pop      = fifo_valid && i_rdata_ready;
  // Nothing in flight and the buffer empties with this cycle's pop.
  assign drain_empty = !rd_vld_p1
                    && (fifo_count == {{(RD_FIFO_CNT_W-1){1'b0}}, rd_pop});

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_rdata_valid = fifo_valid;
  assign o_rdata       = fifo_data;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          state_d = i_cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_beat && last_word) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_issue && last_word) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and handshake decode; the SRAM port is driven combinationally so
  // a write beat lands on the SRAM in the same cycle it is accepted.
  always_comb begin
    o_cmd_ready   = 1'b0;
    o_wdata_ready = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_addr    = addr_q;
    o_mem_data    = '0;
    wr_beat       = 1'b0;
    rd_issue      = 1'b0;
    burst_end     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
      end
      ST_WRITE: begin
        o_wdata_ready = 1'b1;
        wr_beat       = i_wdata_valid;
        o_mem_write   = i_wdata_valid;
        o_mem_data    = i_wdata_valid ? i_wdata : '0;
        burst_end     = i_wdata_valid && last_word;
      end
      ST_READ: begin
        rd_issue = rd_slot_free(fifo_count, rd_vld_p1, rd_pop);
      end
      ST_DRAIN: begin
        burst_end = drain_empty;
      end
      default: begin
        o_cmd_ready = 1'b0;
      end
    endcase
  end

  // Burst bookkeeping: address/count advance per issued word, read-valid
  // pipe tracks the SRAM's one-cycle read latency, done is a 1-cycle pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_vld_p1 <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q <= i_cmd_addr;
        len_q  <= i_cmd_len;
        cnt_q  <= '0;
      end else if (wr_beat || rd_issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        cnt_q  <= cnt_q + LEN_WIDTH'(1);
      end
      rd_vld_p1 <= rd_issue;
      done_q    <= burst_end;
    end
  end

  // Read-data buffer; captures SRAM output the cycle after each issued read.
  sram_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rd_vld_p1),
    .i_data  (i_mem_data),
    .i_pop   (rd_pop),
    .o_valid (fifo_valid),
    .o_data  (fifo_data),
    .o_count (fifo_count)
  );

endmodule
